drp_sequencer: RTL and testbench

DRP_SEQUENCER -- requirements
Module: drp_sequencer

---
 rtl/drp_sequencer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_drp_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drp_sequencer.sv
// ---------------------------------------------------------------------------
// drp_sequencer
//
// Purpose:
//   Serialises read, write and read-modify-write commands onto one of
//   NUM_PORTS DRP (dynamic reconfiguration port) slaves. Address and write
//   data buses are shared. Only the enable/write-enable of the selected port
//   is pulsed. Each DRP access is bounded by an optional wait-cycle timeout.
//   Every command, including an illegal one, gets exactly one response.
//
// Ports:
//   clk, rst     - clock (rising edge), asynchronous active-high reset
//   cmd_*        - command channel (valid/ready). op: 00 rd, 01 wr, 10 rmw,
//                  11 illegal. port/addr/data/mask are latched on accept.
//   rsp_*        - response channel (valid/ready) carrying read data + error
//   drp_addr/di  - shared DRP address / write data
//   drp_en/we    - per-port enable / write enable (one-cycle pulses)
//   drp_rdy/do   - per-port ready / read data (port i at [i*DW +: DW])
//   busy         - high whenever a command is in flight or awaiting response
//   err_count    - saturating count of error responses
// ---------------------------------------------------------------------------
module drp_sequencer #(
   parameter int  NUM_PORTS      = 1,
   parameter int  ADDR_WIDTH     = 9,
   parameter int  DATA_WIDTH     = 16,
   parameter int  TIMEOUT_CYCLES = 255,
   localparam int PW             = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic [1:0]                      cmd_op,
   input  logic [PW-1:0]                   cmd_port,
   input  logic [ADDR_WIDTH-1:0]           cmd_addr,
   input  logic [DATA_WIDTH-1:0]           cmd_data,
   input  logic [DATA_WIDTH-1:0]           cmd_mask,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [DATA_WIDTH-1:0]           rsp_data,
   output logic                            rsp_err,
   output logic [ADDR_WIDTH-1:0]           drp_addr,
   output logic [DATA_WIDTH-1:0]           drp_di,
   output logic [NUM_PORTS-1:0]            drp_en,
   output logic [NUM_PORTS-1:0]            drp_we,
   input  logic [NUM_PORTS-1:0]            drp_rdy,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] drp_do,
   output logic                            busy,
   output logic [7:0]                      err_count
);

   // Counter just wide enough to reach TIMEOUT_CYCLES.
   localparam int            TW          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] TMO_LIMIT   = TW'(TIMEOUT_CYCLES);
   localparam logic          TMO_ENABLED = (TIMEOUT_CYCLES != 0);

   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_RMW = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      RD_EN,
      RD_WAIT,
      WR_EN,
      WR_WAIT,
      RESP
   } state_t;

   state_t                  r_state;
   logic [1:0]              r_op;
   logic [PW-1:0]           r_port;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [DATA_WIDTH-1:0]   r_mask;
   logic [DATA_WIDTH-1:0]   r_old;
   logic [TW-1:0]           r_tmo;
   logic                    r_cmd_ready;
   logic                    r_rsp_valid;
   logic [DATA_WIDTH-1:0]   r_rsp_data;
   logic                    r_rsp_err;
   logic [ADDR_WIDTH-1:0]   r_drp_addr;
   logic [DATA_WIDTH-1:0]   r_drp_di;
   logic [NUM_PORTS-1:0]    r_drp_en;
   logic [NUM_PORTS-1:0]    r_drp_we;
   logic                    r_busy;
   logic [7:0]              r_err_count;

   logic [NUM_PORTS-1:0]    w_cmd_onehot;
   logic [NUM_PORTS-1:0]    w_port_onehot;
   logic                    w_cmd_port_bad;
   logic                    w_rdy_sel;
   logic [DATA_WIDTH-1:0]   w_do_masked [NUM_PORTS];
   logic [DATA_WIDTH-1:0]   w_do_sel;
   logic [DATA_WIDTH-1:0]   w_rmw_val;
   logic [TW-1:0]           w_tmo_next;
   logic                    w_tmo_hit;
   logic [7:0]              w_err_count_inc;

   // One-hot decode of the incoming and the latched port number. A cmd_port
   // beyond NUM_PORTS-1 decodes to all zeros, which flags it as illegal.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign w_cmd_onehot[gi]  = (cmd_port == PW'(gi));
         assign w_port_onehot[gi] = (r_port == PW'(gi));
         assign w_do_masked[gi]   = drp_do[gi*DATA_WIDTH +: DATA_WIDTH]
                                    & {DATA_WIDTH{w_port_onehot[gi]}};
      end
   endgenerate

   assign w_cmd_port_bad = ~|w_cmd_onehot;
   // Only the selected port's ready is ever looked at.
   assign w_rdy_sel      = |(drp_rdy & w_port_onehot);

   always_comb begin
      w_do_sel = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_do_sel = w_do_sel | w_do_masked[i];
      end
   end

   assign w_rmw_val       = (w_do_sel & ~r_mask) | (r_data & r_mask);
   assign w_tmo_next      = r_tmo + TW'(1);
   assign w_tmo_hit       = TMO_ENABLED && (w_tmo_next == TMO_LIMIT);
   assign w_err_count_inc = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_op        <= '0;
         r_port      <= '0;
         r_data      <= '0;
         r_mask      <= '0;
         r_old       <= '0;
         r_tmo       <= '0;
         r_cmd_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
         r_drp_addr  <= '0;
         r_drp_di    <= '0;
         r_drp_en    <= '0;
         r_drp_we    <= '0;
         r_busy      <= 1'b0;
         r_err_count <= '0;
      end else begin
         // Enables are single-cycle pulses; they are re-asserted only on
         // entry to an *_EN state below.
         r_drp_en <= '0;
         r_drp_we <= '0;

         case (r_state)
            IDLE: begin
               // Also raises cmd_ready on the first cycle after reset.
               r_cmd_ready <= 1'b1;
               if (cmd_valid && r_cmd_ready) begin
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_op        <= cmd_op;
                  r_port      <= cmd_port;
                  r_data      <= cmd_data;
                  r_mask      <= cmd_mask;
                  r_tmo       <= '0;
                  if (cmd_op == OP_ILL || w_cmd_port_bad) begin
                     r_state     <= RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_data  <= '0;
                     r_rsp_err   <= 1'b1;
                     r_err_count <= w_err_count_inc;
                  end else begin
                     r_drp_addr <= cmd_addr;
                     r_drp_en   <= w_cmd_onehot;
                     if (cmd_op == OP_WR) begin
                        r_state  <= WR_EN;
                        r_drp_we <= w_cmd_onehot;
                        r_drp_di <= cmd_data;
                     end else begin
                        r_state <= RD_EN;
                     end
                  end
               end
            end

            RD_EN: begin
               r_tmo   <= '0;
               r_state <= RD_WAIT;
            end

            RD_WAIT: begin
               if (w_rdy_sel) begin
                  r_old <= w_do_sel;
                  if (r_op == OP_RMW) begin
                     r_state  <= WR_EN;
                     r_drp_en <= w_port_onehot;
                     r_drp_we <= w_port_onehot;
                     r_drp_di <= w_rmw_val;
                  end else begin
                     r_state     <= RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_data  <= w_do_sel;
                     r_rsp_err   <= 1'b0;
                  end
               end else begin
                  r_tmo <= w_tmo_next;
                  // A timed-out RMW read never reaches the write phase.
                  if (w_tmo_hit) begin
                     r_state     <= RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_data  <= '0;
                     r_rsp_err   <= 1'b1;
                     r_err_count <= w_err_count_inc;
                  end
               end
            end

            WR_EN: begin
               r_tmo   <= '0;
               r_state <= WR_WAIT;
            end

            WR_WAIT: begin
               if (w_rdy_sel) begin
                  r_state     <= RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= (r_op == OP_RMW) ? r_old : '0;
                  r_rsp_err   <= 1'b0;
               end else begin
                  r_tmo <= w_tmo_next;
                  if (w_tmo_hit) begin
                     r_state     <= RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_data  <= '0;
                     r_rsp_err   <= 1'b1;
                     r_err_count <= w_err_count_inc;
                  end
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;
   assign drp_addr  = r_drp_addr;
   assign drp_di    = r_drp_di;
   assign drp_en    = r_drp_en;
   assign drp_we    = r_drp_we;
   assign busy      = r_busy;
   assign err_count = r_err_count;

endmodule

// File: tb/tb_drp_sequencer.sv
// ---------------------------------------------------------------------------
// tb_drp_sequencer
//
// Directed bench for drp_sequencer. Instance "a" serves three ports with a
// four-cycle timeout and covers RMW, timeout, illegal commands, response
// back-pressure and mid-transaction reset. Instance "b" is the default
// single-port build used for the basic read and the out-of-range port.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_drp_sequencer;

   logic clk;
   logic rst;

   // ---------------- instance a: 3 ports, timeout 4 ----------------
   logic        a_cmd_valid, a_cmd_ready;
   logic [1:0]  a_cmd_op;
   logic [1:0]  a_cmd_port;
   logic [8:0]  a_cmd_addr;
   logic [15:0] a_cmd_data, a_cmd_mask;
   logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
   logic [15:0] a_rsp_data;
   logic [8:0]  a_drp_addr;
   logic [15:0] a_drp_di;
   logic [2:0]  a_drp_en, a_drp_we, a_drp_rdy;
   logic [47:0] a_drp_do;
   logic        a_busy;
   logic [7:0]  a_err_count;

   // ---------------- instance b: 1 port, default timeout ----------------
   logic        b_cmd_valid, b_cmd_ready;
   logic [1:0]  b_cmd_op;
   logic [0:0]  b_cmd_port;
   logic [8:0]  b_cmd_addr;
   logic [15:0] b_cmd_data, b_cmd_mask;
   logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
   logic [15:0] b_rsp_data;
   logic [8:0]  b_drp_addr;
   logic [15:0] b_drp_di;
   logic [0:0]  b_drp_en, b_drp_we, b_drp_rdy;
   logic [15:0] b_drp_do;
   logic        b_busy;
   logic [7:0]  b_err_count;

   int n_cmp = 0;
   int n_err = 0;

   drp_sequencer #(
      .NUM_PORTS(3), .ADDR_WIDTH(9), .DATA_WIDTH(16), .TIMEOUT_CYCLES(4)
   ) dut_a (
      .clk(clk), .rst(rst),
      .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_op(a_cmd_op),
      .cmd_port(a_cmd_port), .cmd_addr(a_cmd_addr), .cmd_data(a_cmd_data),
      .cmd_mask(a_cmd_mask),
      .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
      .rsp_err(a_rsp_err),
      .drp_addr(a_drp_addr), .drp_di(a_drp_di), .drp_en(a_drp_en),
      .drp_we(a_drp_we), .drp_rdy(a_drp_rdy), .drp_do(a_drp_do),
      .busy(a_busy), .err_count(a_err_count)
   );

   drp_sequencer dut_b (
      .clk(clk), .rst(rst),
      .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(b_cmd_op),
      .cmd_port(b_cmd_port), .cmd_addr(b_cmd_addr), .cmd_data(b_cmd_data),
      .cmd_mask(b_cmd_mask),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
      .rsp_err(b_rsp_err),
      .drp_addr(b_drp_addr), .drp_di(b_drp_di), .drp_en(b_drp_en),
      .drp_we(b_drp_we), .drp_rdy(b_drp_rdy), .drp_do(b_drp_do),
      .busy(b_busy), .err_count(b_err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Absolute bound on run time.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Presents one command to instance a; returns one cycle after the
   // accepting edge (cycle 1 of the transaction).
   task automatic send_a(input logic [1:0] op, input logic [1:0] port,
                         input logic [8:0] addr, input logic [15:0] data,
                         input logic [15:0] mask);
      check("a_cmd_ready_before_send", a_cmd_ready, 1'b1);
      a_cmd_op    = op;
      a_cmd_port  = port;
      a_cmd_addr  = addr;
      a_cmd_data  = data;
      a_cmd_mask  = mask;
      a_cmd_valid = 1'b1;
      tick();
      a_cmd_valid = 1'b0;
      $display("cmd a: op=%0d port=%0d addr=0x%03h data=0x%04h mask=0x%04h",
               op, port, addr, data, mask);
   endtask

   initial begin
      rst = 1'b1;
      a_cmd_valid = 0; a_cmd_op = 0; a_cmd_port = 0; a_cmd_addr = 0;
      a_cmd_data = 0; a_cmd_mask = 0; a_rsp_ready = 1; a_drp_rdy = 0; a_drp_do = 0;
      b_cmd_valid = 0; b_cmd_op = 0; b_cmd_port = 0; b_cmd_addr = 0;
      b_cmd_data = 0; b_cmd_mask = 0; b_rsp_ready = 1; b_drp_rdy = 0; b_drp_do = 0;

      // ---------------- reset state ----------------
      tick();
      tick();
      check("rst_cmd_ready", a_cmd_ready, 1'b0);
      check("rst_rsp_valid", a_rsp_valid, 1'b0);
      check("rst_drp_en",    a_drp_en,    3'b000);
      check("rst_drp_addr",  a_drp_addr,  9'h000);
      check("rst_busy",      a_busy,      1'b0);
      check("rst_err_count", a_err_count, 8'd0);
      rst = 1'b0;
      tick();
      check("post_rst_cmd_ready_a", a_cmd_ready, 1'b1);
      check("post_rst_cmd_ready_b", b_cmd_ready, 1'b1);
      $display("reset released");

      // ---------------- b: basic read, 1 port ----------------
      b_cmd_op = 2'b00; b_cmd_port = 1'b0; b_cmd_addr = 9'h0A5; b_cmd_valid = 1'b1;
      tick();                                   // accept edge = cycle 0
      b_cmd_valid = 1'b0;
      check("b_rd_en_c1",   b_drp_en,   1'b1);
      check("b_rd_we_c1",   b_drp_we,   1'b0);
      check("b_rd_addr_c1", b_drp_addr, 9'h0A5);
      tick();                                   // cycle 2: RD_WAIT
      b_drp_rdy = 1'b1; b_drp_do = 16'h1234;
      check("b_rd_en_c2",  b_drp_en,    1'b0);
      check("b_rd_rv_c2",  b_rsp_valid, 1'b0);
      tick();                                   // cycle 3: response
      b_drp_rdy = 1'b0;
      check("b_rd_rv_c3",   b_rsp_valid, 1'b1);
      check("b_rd_data_c3", b_rsp_data,  16'h1234);
      check("b_rd_err_c3",  b_rsp_err,   1'b0);
      $display("rsp b: read addr 0x0A5 data=0x%04h err=%0d", b_rsp_data, b_rsp_err);
      tick();
      check("b_rd_idle_ready", b_cmd_ready, 1'b1);

      // b: cmd_port=1 with a single port is out of range
      b_cmd_op = 2'b00; b_cmd_port = 1'b1; b_cmd_addr = 9'h011; b_cmd_valid = 1'b1;
      tick();
      b_cmd_valid = 1'b0;
      check("b_badport_rv",   b_rsp_valid, 1'b1);
      check("b_badport_err",  b_rsp_err,   1'b1);
      check("b_badport_data", b_rsp_data,  16'h0000);
      check("b_badport_en",   b_drp_en,    1'b0);
      check("b_badport_cnt",  b_err_count, 8'd1);
      $display("rsp b: bad port err=%0d err_count=%0d", b_rsp_err, b_err_count);
      tick();

      // ---------------- a: RMW on port 1 ----------------
      a_drp_do = {16'h2222, 16'hF0F0, 16'h1111};
      send_a(2'b10, 2'd1, 9'h123, 16'h0A0A, 16'h00FF);
      check("rmw_rd_en",   a_drp_en,   3'b010);
      check("rmw_rd_we",   a_drp_we,   3'b000);
      check("rmw_rd_addr", a_drp_addr, 9'h123);
      check("rmw_busy",    a_busy,     1'b1);
      check("rmw_cmd_rdy", a_cmd_ready, 1'b0);
      a_drp_rdy = 3'b111;                       // must be ignored during RD_EN
      tick();                                   // cycle 2
      check("rmw_rd_wait_en", a_drp_en, 3'b000);
      check("rmw_rd_wait_we", a_drp_we, 3'b000);
      a_drp_rdy = 3'b101;                       // other ports only
      tick();                                   // cycle 3: still waiting
      check("rmw_other_rdy_en", a_drp_en,    3'b000);
      check("rmw_other_rdy_rv", a_rsp_valid, 1'b0);
      a_drp_rdy = 3'b010;
      tick();                                   // cycle 4: WR_EN
      check("rmw_wr_en",   a_drp_en,   3'b010);
      check("rmw_wr_we",   a_drp_we,   3'b010);
      check("rmw_wr_di",   a_drp_di,   16'hF00A);
      check("rmw_wr_addr", a_drp_addr, 9'h123);
      tick();                                   // cycle 5: WR_WAIT (rdy in WR_EN ignored)
      check("rmw_wr_wait_rv", a_rsp_valid, 1'b0);
      check("rmw_wr_wait_en", a_drp_en,    3'b000);
      check("rmw_wr_wait_addr", a_drp_addr, 9'h123);
      a_drp_rdy = 3'b000;
      tick();                                   // cycle 6
      check("rmw_no_rdy_rv", a_rsp_valid, 1'b0);
      a_drp_rdy = 3'b010;
      tick();                                   // cycle 7: response
      a_drp_rdy = 3'b000;
      check("rmw_rv",   a_rsp_valid, 1'b1);
      check("rmw_data", a_rsp_data,  16'hF0F0);
      check("rmw_err",  a_rsp_err,   1'b0);
      check("rmw_cnt",  a_err_count, 8'd0);
      $display("rsp a: rmw data=0x%04h err=%0d", a_rsp_data, a_rsp_err);
      tick();
      check("rmw_done_rv",   a_rsp_valid, 1'b0);
      check("rmw_done_busy", a_busy,      1'b0);

      // ---------------- a: write timeout on port 0 ----------------
      send_a(2'b01, 2'd0, 9'h055, 16'hBEEF, 16'h0000);
      check("wto_en", a_drp_en, 3'b001);
      check("wto_we", a_drp_we, 3'b001);
      check("wto_di", a_drp_di, 16'hBEEF);
      a_drp_rdy = 3'b110;                       // wrong ports, must not count as ready
      tick(); tick(); tick(); tick();           // cycles 2..5: four wait cycles
      check("wto_rv_c5", a_rsp_valid, 1'b0);
      tick();                                   // cycle 6
      a_drp_rdy = 3'b000;
      check("wto_rv",   a_rsp_valid, 1'b1);
      check("wto_err",  a_rsp_err,   1'b1);
      check("wto_data", a_rsp_data,  16'h0000);
      check("wto_cnt",  a_err_count, 8'd1);
      $display("rsp a: write timeout err=%0d err_count=%0d", a_rsp_err, a_err_count);
      tick();

      // ---------------- a: illegal op, then out-of-range port ----------------
      send_a(2'b11, 2'd0, 9'h001, 16'h0000, 16'h0000);
      check("ill_rv",   a_rsp_valid, 1'b1);
      check("ill_err",  a_rsp_err,   1'b1);
      check("ill_data", a_rsp_data,  16'h0000);
      check("ill_en",   a_drp_en,    3'b000);
      check("ill_cnt",  a_err_count, 8'd2);
      $display("rsp a: illegal op err=%0d err_count=%0d", a_rsp_err, a_err_count);
      tick();
      send_a(2'b00, 2'd3, 9'h002, 16'h0000, 16'h0000);
      check("port3_rv",  a_rsp_valid, 1'b1);
      check("port3_err", a_rsp_err,   1'b1);
      check("port3_en",  a_drp_en,    3'b000);
      check("port3_cnt", a_err_count, 8'd3);
      $display("rsp a: bad port err=%0d err_count=%0d", a_rsp_err, a_err_count);
      tick();

      // ---------------- a: response back-pressure ----------------
      a_drp_do = {16'hA5A5, 16'h0000, 16'h0000};
      send_a(2'b00, 2'd2, 9'h1FF, 16'h0000, 16'h0000);
      check("bp_en", a_drp_en, 3'b100);
      tick();
      a_drp_rdy = 3'b100;
      tick();                                   // cycle 3: response
      a_drp_rdy = 3'b000;
      a_rsp_ready = 1'b0;
      a_drp_do = {16'h5555, 16'h0000, 16'h0000}; // must not disturb held response
      for (int k = 0; k < 5; k++) begin
         check("bp_hold_rv",   a_rsp_valid, 1'b1);
         check("bp_hold_data", a_rsp_data,  16'hA5A5);
         check("bp_hold_rdy",  a_cmd_ready, 1'b0);
         tick();
      end
      a_rsp_ready = 1'b1;
      check("bp_last_rv", a_rsp_valid, 1'b1);
      tick();
      check("bp_rel_rv",  a_rsp_valid, 1'b0);
      check("bp_rel_rdy", a_cmd_ready, 1'b1);
      $display("rsp a: back-pressured read released, cmd_ready=%0d", a_cmd_ready);

      // ---------------- a: reset during RD_WAIT ----------------
      send_a(2'b00, 2'd0, 9'h0C3, 16'h0000, 16'h0000);
      check("rr_en", a_drp_en, 3'b001);
      tick();                                   // RD_WAIT
      rst = 1'b1;
      a_drp_rdy = 3'b001;
      #1;
      check("rr_async_busy", a_busy,      1'b0);
      check("rr_async_addr", a_drp_addr,  9'h000);
      check("rr_async_cnt",  a_err_count, 8'd0);
      check("rr_async_rdy",  a_cmd_ready, 1'b0);
      tick();
      check("rr_rv",  a_rsp_valid, 1'b0);
      check("rr_en0", a_drp_en,    3'b000);
      rst = 1'b0;
      a_drp_rdy = 3'b000;
      tick();
      check("rr_after_rv",  a_rsp_valid, 1'b0);
      check("rr_after_rdy", a_cmd_ready, 1'b1);
      $display("reset during RD_WAIT: rsp_valid=%0d cmd_ready=%0d", a_rsp_valid, a_cmd_ready);
      a_drp_do = {16'h0000, 16'h0000, 16'h5A5A};
      send_a(2'b00, 2'd0, 9'h0C3, 16'h0000, 16'h0000);
      check("rr2_en", a_drp_en, 3'b001);
      tick();
      a_drp_rdy = 3'b001;
      tick();
      a_drp_rdy = 3'b000;
      check("rr2_rv",   a_rsp_valid, 1'b1);
      check("rr2_data", a_rsp_data,  16'h5A5A);
      check("rr2_err",  a_rsp_err,   1'b0);
      $display("rsp a: read after reset data=0x%04h err=%0d", a_rsp_data, a_rsp_err);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
